tpc_sram_port_arbiter: RTL and testbench

//   Shares the TPC's banked local SRAM among four requesters: MXU, VPU, DMA and NoC-RX.

---
 rtl/tpc_pkg.sv | 34 +++
 rtl/tpc_sram_port_arbiter_rr_arbiter.sv | 42 ++++
 rtl/tpc_sram_port_arbiter.sv | 99 +++++++++
 tb/tb_tpc_sram_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpc_pkg.sv
// Shared constants, address decode helpers and response tag type for the TPC
// local-SRAM port arbiter.
package tpc_pkg;

  localparam int NREQ   = 4;
  localparam int BANKS  = 4;
  localparam int DEPTH  = 256;
  localparam int DATA_W = 256;
  localparam int ADDR_W = 20;
  localparam int BANK_W = $clog2(BANKS);
  localparam int WORD_W = $clog2(DEPTH);
  localparam int ID_W   = $clog2(NREQ);

  localparam logic [ID_W-1:0] REQ_MXU = ID_W'(0);
  localparam logic [ID_W-1:0] REQ_VPU = ID_W'(1);
  localparam logic [ID_W-1:0] REQ_DMA = ID_W'(2);
  localparam logic [ID_W-1:0] REQ_NOC = ID_W'(3);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } rsp_tag_t;

  // Banks are interleaved on the low address bits; bits above the word
  // index are simply dropped.
  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
    return a[BANK_W-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return a[BANK_W +: WORD_W];
  endfunction

endpackage

// File: rtl/tpc_sram_port_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant plus winner index; the pointer
// advances past the winner only on cycles that grant.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] win_o,
  output logic          any_o
);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    logic [IW-1:0] idx;
    logic          found;
    idx   = '0;
    found = 1'b0;
    gnt_o = '0;
    win_o = '0;
    ptr_d = ptr_q;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr_q) + i) % N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win_o      = idx;
        ptr_d      = IW'((int'(idx) + 1) % N);
      end
    end
    any_o = found;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tpc_sram_port_arbiter.sv
// Per-bank round-robin sharing of the TPC local SRAM among MXU/VPU/DMA/NOC,
// with one-cycle read data routed back through a per-bank owner tag.
module tpc_sram_port_arbiter
  import tpc_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ-1:0]                req_we,
  input  logic [NREQ-1:0][ADDR_W-1:0]    req_addr,
  input  logic [NREQ-1:0][DATA_W-1:0]    req_wdata,
  output logic [NREQ-1:0]                req_ready,
  output logic [NREQ-1:0]                rsp_valid,
  output logic [NREQ-1:0][DATA_W-1:0]    rsp_rdata,
  output logic [BANKS-1:0]               bank_en,
  output logic [BANKS-1:0]               bank_we,
  output logic [BANKS-1:0][WORD_W-1:0]   bank_addr,
  output logic [BANKS-1:0][DATA_W-1:0]   bank_wdata,
  input  logic [BANKS-1:0][DATA_W-1:0]   bank_rdata,
  output logic [31:0]                    stall_cnt
);

  logic [BANKS-1:0][NREQ-1:0] bank_req, bank_gnt;
  logic [BANKS-1:0][ID_W-1:0] bank_win;
  logic [BANKS-1:0]           bank_any;
  rsp_tag_t [BANKS-1:0]       tag_q, tag_d;
  logic [NREQ-1:0][DATA_W-1:0] rdata_q;
  logic [31:0]                stall_cnt_q, stall_cnt_d;

  always_comb begin
    bank_req = '0;
    for (int b = 0; b < BANKS; b++)
      for (int r = 0; r < NREQ; r++)
        bank_req[b][r] = req_valid[r] && (bank_of(req_addr[r]) == BANK_W'(b));
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    rr_arbiter #(.N(NREQ)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (bank_req[b]),
      .gnt_o (bank_gnt[b]),
      .win_o (bank_win[b]),
      .any_o (bank_any[b])
    );
  end

  always_comb begin
    req_ready  = '0;
    bank_en    = '0;
    bank_we    = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    tag_d      = '0;
    for (int b = 0; b < BANKS; b++) begin
      bank_en[b]    = bank_any[b] && !rst;
      bank_we[b]    = bank_en[b] && req_we[bank_win[b]];
      bank_addr[b]  = word_of(req_addr[bank_win[b]]);
      bank_wdata[b] = req_wdata[bank_win[b]];
      tag_d[b].vld  = bank_en[b] && !bank_we[b];
      tag_d[b].id   = bank_win[b];
      if (!rst) req_ready = req_ready | bank_gnt[b];
    end
  end

  // A requester is granted at most one bank per cycle and tags live one
  // cycle, so at most one tag can name a given requester.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = rdata_q;
    for (int b = 0; b < BANKS; b++) begin
      if (tag_q[b].vld) begin
        rsp_valid[tag_q[b].id] = 1'b1;
        rsp_rdata[tag_q[b].id] = bank_rdata[b];
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (|(req_valid & ~req_ready) && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q       <= '0;
      rdata_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      tag_q       <= tag_d;
      rdata_q     <= rsp_rdata;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_tpc_sram_port_arbiter.sv
// Bench for tpc_sram_port_arbiter: vector table, directed corner sequences and
// a randomized run against an arithmetic reference model with a shadow SRAM.
module tb_tpc_sram_port_arbiter;
  import tpc_pkg::*;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic [NREQ-1:0]               req_valid = '0, req_we = '0;
  logic [NREQ-1:0][ADDR_W-1:0]   req_addr = '0;
  logic [NREQ-1:0][DATA_W-1:0]   req_wdata = '0;
  logic [NREQ-1:0]               req_ready, rsp_valid;
  logic [NREQ-1:0][DATA_W-1:0]   rsp_rdata;
  logic [BANKS-1:0]              bank_en, bank_we;
  logic [BANKS-1:0][WORD_W-1:0]  bank_addr;
  logic [BANKS-1:0][DATA_W-1:0]  bank_wdata;
  logic [BANKS-1:0][DATA_W-1:0]  bank_rdata = '0;
  logic [31:0]                   stall_cnt;

  int errors = 0;
  int checks = 0;

  tpc_sram_port_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .bank_en(bank_en),
    .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pat(input int b, input int w);
    logic [DATA_W-1:0] p;
    for (int k = 0; k < DATA_W / 32; k++) p[k*32 +: 32] = {8'(b), 8'(w), 8'(k), 8'hA5};
    return p;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] d;
    for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // SRAM banks seen by the DUT: unwritten words read back as pat()
  logic [DATA_W-1:0] s_mem [BANKS][DEPTH];
  bit                s_wr  [BANKS][DEPTH];
  always @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (bank_en[b]) begin
        if (bank_we[b]) begin
          s_mem[b][bank_addr[b]] <= bank_wdata[b];
          s_wr[b][bank_addr[b]]  <= 1'b1;
        end else begin
          bank_rdata[b] <= s_wr[b][bank_addr[b]] ? s_mem[b][bank_addr[b]] : pat(b, int'(bank_addr[b]));
        end
      end
    end
  end

  // Shadow of what the SRAM should contain, kept from requester writes
  logic [DATA_W-1:0] e_mem [BANKS][DEPTH];
  bit                e_wr  [BANKS][DEPTH];
  function automatic logic [DATA_W-1:0] e_rd(input int b, input int w);
    return e_wr[b][w] ? e_mem[b][w] : pat(b, w);
  endfunction

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [NREQ-1:0]             vld;
    logic [NREQ-1:0][ADDR_W-1:0] addr;
    logic [NREQ-1:0]             rdy;
    logic [BANKS-1:0]            en;
    logic [WORD_W-1:0]           w0;
  } vec_t;

  function automatic vec_t mk(input logic [NREQ-1:0] v, input logic [ADDR_W-1:0] a0, a1, a2, a3,
                              input logic [NREQ-1:0] rdy, input logic [BANKS-1:0] en,
                              input logic [WORD_W-1:0] w0);
    vec_t t;
    t.vld = v; t.addr[0] = a0; t.addr[1] = a1; t.addr[2] = a2; t.addr[3] = a3;
    t.rdy = rdy; t.en = en; t.w0 = w0;
    return t;
  endfunction

  // Reference model state for the randomized run
  int                m_ptr [BANKS];
  logic [31:0]       m_stall;
  logic [NREQ-1:0]   m_pv, m_gnt;
  logic [DATA_W-1:0] m_pd [NREQ];
  logic [DATA_W-1:0] m_last [NREQ];

  task automatic model_cycle();
    int win [BANKS];
    logic [NREQ-1:0]  e_rdy;
    logic [BANKS-1:0] e_en, e_we;
    int w;
    e_rdy = '0; e_en = '0; e_we = '0;
    for (int b = 0; b < BANKS; b++) begin
      win[b] = -1;
      for (int i = 0; i < NREQ; i++) begin
        int r;
        r = (m_ptr[b] + i) % NREQ;
        if (win[b] < 0 && req_valid[r] && int'(req_addr[r]) % BANKS == b) win[b] = r;
      end
      if (win[b] >= 0) begin
        e_rdy[win[b]] = 1'b1;
        e_en[b] = 1'b1;
        e_we[b] = req_we[win[b]];
      end
    end
    chk("rnd req_ready", DATA_W'(req_ready), DATA_W'(e_rdy));
    chk("rnd bank_en", DATA_W'(bank_en), DATA_W'(e_en));
    chk("rnd bank_we", DATA_W'(bank_we), DATA_W'(e_we));
    for (int b = 0; b < BANKS; b++) begin
      if (win[b] >= 0) begin
        w = (int'(req_addr[win[b]]) / BANKS) % DEPTH;
        chk("rnd bank_addr", DATA_W'(bank_addr[b]), DATA_W'(w));
        if (e_we[b]) chk("rnd bank_wdata", bank_wdata[b], req_wdata[win[b]]);
      end
    end
    chk("rnd rsp_valid", DATA_W'(rsp_valid), DATA_W'(m_pv));
    for (int r = 0; r < NREQ; r++) begin
      chk("rnd rsp_rdata", rsp_rdata[r], m_pv[r] ? m_pd[r] : m_last[r]);
      if (m_pv[r]) m_last[r] = m_pd[r];
    end
    chk("rnd stall_cnt", DATA_W'(stall_cnt), DATA_W'(m_stall));
    m_pv = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (win[b] >= 0) begin
        w = (int'(req_addr[win[b]]) / BANKS) % DEPTH;
        if (e_we[b]) begin
          e_mem[b][w] = req_wdata[win[b]];
          e_wr[b][w]  = 1'b1;
        end else begin
          m_pv[win[b]] = 1'b1;
          m_pd[win[b]] = e_rd(b, w);
        end
        m_ptr[b] = (win[b] + 1) % NREQ;
      end
    end
    if ((req_valid & ~e_rdy) != '0 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    m_gnt = e_rdy;
  endtask

  logic [DATA_W-1:0] d_wr;
  logic [ADDR_W-1:0] a;
  vec_t tbl [8];

  initial begin
    // Reset state while rst is still high, with a request pending
    @(negedge clk);
    req_valid = 4'b0011; req_addr[0] = 20'h20; req_addr[1] = 20'h21;
    #1;
    chk("rst req_ready", DATA_W'(req_ready), '0);
    chk("rst bank_en", DATA_W'(bank_en), '0);
    chk("rst rsp_valid", DATA_W'(rsp_valid), '0);
    chk("rst stall_cnt", DATA_W'(stall_cnt), '0);
    chk("rst rsp_rdata0", rsp_rdata[0], '0);
    do_reset();

    // Table: applied back to back from reset, so rr pointers carry over
    tbl[0] = mk(4'b0010, 0, 20'h20, 0, 0, 4'b0010, 4'b0001, 8'd8);
    tbl[1] = mk(4'b1111, 20'h20, 20'h21, 20'h22, 20'h23, 4'b1111, 4'b1111, 8'd8);
    tbl[2] = mk(4'b0101, 20'h20, 0, 20'h24, 0, 4'b0100, 4'b0001, 8'd9);
    tbl[3] = mk(4'b0101, 20'h20, 0, 20'h24, 0, 4'b0001, 4'b0001, 8'd8);
    tbl[4] = mk(4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 8'd0);
    tbl[5] = mk(4'b1010, 0, 20'h21, 0, 20'h25, 4'b1000, 4'b0010, 8'd0);
    tbl[6] = mk(4'b0001, 20'hFFFF0, 0, 0, 0, 4'b0001, 4'b0001, 8'hFC);
    tbl[7] = mk(4'b1111, 20'h2, 20'h6, 20'hA, 20'hE, 4'b1000, 4'b0100, 8'd0);
    for (int i = 0; i < 8; i++) begin
      req_valid = tbl[i].vld; req_addr = tbl[i].addr; req_we = '0;
      #1;
      chk($sformatf("tbl%0d ready", i), DATA_W'(req_ready), DATA_W'(tbl[i].rdy));
      chk($sformatf("tbl%0d bank_en", i), DATA_W'(bank_en), DATA_W'(tbl[i].en));
      if (tbl[i].en[0]) chk($sformatf("tbl%0d bank_addr0", i), DATA_W'(bank_addr[0]), DATA_W'(tbl[i].w0));
      @(negedge clk);
    end

    // Single VPU read: same-cycle grant, data the next cycle, then held
    do_reset();
    req_valid = 4'b0010; req_addr[1] = 20'h20;
    #1;
    chk("t1 ready", DATA_W'(req_ready), DATA_W'(4'b0010));
    chk("t1 bank_en", DATA_W'(bank_en), DATA_W'(4'b0001));
    chk("t1 bank_addr", DATA_W'(bank_addr[0]), DATA_W'(8));
    @(negedge clk); idle(); #1;
    chk("t1 rsp_valid", DATA_W'(rsp_valid), DATA_W'(4'b0010));
    chk("t1 rsp_rdata", rsp_rdata[1], pat(0, 8));
    @(negedge clk); #1;
    chk("t1 rsp pulse", DATA_W'(rsp_valid), '0);
    chk("t1 rdata hold", rsp_rdata[1], pat(0, 8));

    // Four-way contention on bank 0: strict rotation, stall every cycle
    do_reset();
    req_valid = '1;
    for (int r = 0; r < NREQ; r++) req_addr[r] = 20'h20;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t2 rr grant", DATA_W'(req_ready), DATA_W'(NREQ'(1) << (i % NREQ)));
      chk("t2 stall_cnt", DATA_W'(stall_cnt), DATA_W'(i));
      if (i > 0) chk("t2 rsp_valid", DATA_W'(rsp_valid), DATA_W'(NREQ'(1) << ((i - 1) % NREQ)));
      @(negedge clk);
    end

    // One requester per bank: all granted together, all respond together
    do_reset();
    req_valid = '1;
    for (int r = 0; r < NREQ; r++) req_addr[r] = ADDR_W'(32 + r);
    #1;
    chk("t3 ready", DATA_W'(req_ready), DATA_W'(4'b1111));
    chk("t3 bank_en", DATA_W'(bank_en), DATA_W'(4'b1111));
    @(negedge clk); idle(); #1;
    chk("t3 rsp_valid", DATA_W'(rsp_valid), DATA_W'(4'b1111));
    for (int r = 0; r < NREQ; r++) chk("t3 rsp_rdata", rsp_rdata[r], pat(r, 8));

    // DMA write then VPU read of the same word
    do_reset();
    d_wr = rnd_data();
    req_valid = 4'b0100; req_we = 4'b0100; req_addr[2] = 20'h24; req_wdata[2] = d_wr;
    #1;
    chk("t4 wr ready", DATA_W'(req_ready), DATA_W'(4'b0100));
    chk("t4 bank_we", DATA_W'(bank_we), DATA_W'(4'b0001));
    chk("t4 bank_addr", DATA_W'(bank_addr[0]), DATA_W'(9));
    chk("t4 bank_wdata", bank_wdata[0], d_wr);
    e_mem[0][9] = d_wr; e_wr[0][9] = 1'b1;
    @(negedge clk); idle();
    req_valid = 4'b0010; req_addr[1] = 20'h24;
    #1;
    chk("t4 rd ready", DATA_W'(req_ready), DATA_W'(4'b0010));
    chk("t4 no wr rsp", DATA_W'(rsp_valid), '0);
    @(negedge clk); idle(); #1;
    chk("t4 rsp_valid", DATA_W'(rsp_valid), DATA_W'(4'b0010));
    chk("t4 rsp_rdata", rsp_rdata[1], d_wr);

    // Reset right after a read grant drops the response and the rr state
    do_reset();
    req_valid = 4'b0010; req_addr[1] = 20'h20;
    #1;
    chk("t5 grant", DATA_W'(req_ready), DATA_W'(4'b0010));
    @(posedge clk);
    rst = 1'b1;
    req_valid = 4'b0011; req_addr[0] = 20'h20;
    #1;
    chk("t5 rsp dropped", DATA_W'(rsp_valid), '0);
    chk("t5 rst ready", DATA_W'(req_ready), '0);
    chk("t5 rst bank_en", DATA_W'(bank_en), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5 mxu first", DATA_W'(req_ready), DATA_W'(4'b0001));
    chk("t5 no rsp", DATA_W'(rsp_valid), '0);
    @(negedge clk); idle(); #1;
    chk("t5 mxu rsp only", DATA_W'(rsp_valid), DATA_W'(4'b0001));

    // Stall counter saturation
    do_reset();
    force dut.stall_cnt_d = 32'hFFFF_FFFE;
    @(posedge clk);
    #1 release dut.stall_cnt_d;
    chk("t6 preload", DATA_W'(stall_cnt), DATA_W'(32'hFFFF_FFFE));
    @(negedge clk);
    req_valid = 4'b0011; req_addr[0] = 20'h20; req_addr[1] = 20'h24;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t6 saturate", DATA_W'(stall_cnt), DATA_W'(32'hFFFF_FFFF));
    end
    idle();

    // Randomized traffic against the reference model
    do_reset();
    for (int b = 0; b < BANKS; b++) m_ptr[b] = 0;
    m_stall = '0; m_pv = '0; m_gnt = '0;
    for (int r = 0; r < NREQ; r++) begin m_pd[r] = '0; m_last[r] = '0; end
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!req_valid[r] || m_gnt[r]) begin
          a = ADDR_W'($urandom_range(0, 23));
          if ($urandom_range(0, 7) == 0) a = a | 20'hFFC00;
          req_valid[r] = ($urandom_range(0, 3) != 0);
          req_we[r]    = ($urandom_range(0, 2) == 0);
          req_addr[r]  = a;
          req_wdata[r] = rnd_data();
        end
      end
      #1;
      model_cycle();
      @(negedge clk);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
